// File: rtl/seq_engine.sv
// Recurrence sequence generator: two seed terms, then T(k) = T(k-2) op T(k-1), written to a result RAM.
// Optional overflow detection is built only when SEQ_OVF_DETECT_EN is defined.
module seq_engine #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AW:0]      n_terms,
    input  logic [WIDTH-1:0] seed0,
    input  logic [WIDTH-1:0] seed1,
    input  logic [1:0]       op,
    output logic             busy,
    output logic             done,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             ovf
);

    typedef enum logic [2:0] {IDLE, SEED0, SEED1, RUN, FIN} state_t;

    localparam logic [AW:0] DEPTH_N = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ONE_N   = (AW + 1)'(1);
    localparam logic [AW:0] TWO_N   = (AW + 1)'(2);

    state_t           state, state_nx;
    logic [WIDTH-1:0] a, b;
    logic [AW:0]      k, n;
    logic [1:0]       op_q;
    logic             accept;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] add_res;
    logic [WIDTH-1:0] result;
    logic [AW:0]      n_clamped;
    logic [WIDTH-1:0] mem [DEPTH];

    assign n_clamped = (n_terms > DEPTH_N) ? DEPTH_N : n_terms;
    assign busy      = (state == SEED0) || (state == SEED1) || (state == RUN);
    assign done      = (state == FIN);

    always_comb begin
        result = '0;
        case (op_q)
            2'b00:   result = add_res;
            2'b01:   result = b - a;
            2'b10:   result = a ^ b;
            default: result = a | b;
        endcase
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        wr_en    = 1'b0;
        wr_data  = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = (n_terms == '0) ? FIN : SEED0;
                end
            end
            SEED0: begin
                wr_en    = 1'b1;
                wr_data  = a;
                state_nx = (n == ONE_N) ? FIN : SEED1;
            end
            SEED1: begin
                wr_en    = 1'b1;
                wr_data  = b;
                state_nx = (n == TWO_N) ? FIN : RUN;
            end
            RUN: begin
                wr_en    = 1'b1;
                wr_data  = result;
                state_nx = (k == n - ONE_N) ? FIN : RUN;
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Seeds are loaded straight into a/b at acceptance so SEED0/SEED1 just write them out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a     <= '0;
            b     <= '0;
            k     <= '0;
            n     <= '0;
            op_q  <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                a    <= seed0;
                b    <= seed1;
                k    <= '0;
                n    <= n_clamped;
                op_q <= op;
            end else if (wr_en) begin
                k <= k + ONE_N;
                if (state == RUN) begin
                    a <= b;
                    b <= result;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[k[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rd_data <= '0;
        else
            rd_data <= mem[rd_addr];
    end

`ifdef SEQ_OVF_DETECT_EN
    logic [WIDTH:0] sum_ext;
    logic           ovf_hit;
    logic           ovf_q;

    assign sum_ext = {1'b0, a} + {1'b0, b};
    assign add_res = sum_ext[WIDTH-1:0];
    assign ovf_hit = (state == RUN) &&
                     (((op_q == 2'b00) && sum_ext[WIDTH]) || ((op_q == 2'b01) && (b < a)));
    assign ovf     = ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf_q <= 1'b0;
        else if (accept)
            ovf_q <= 1'b0;
        else if (ovf_hit)
            ovf_q <= 1'b1;
    end
`else
    assign add_res = a + b;
    assign ovf     = 1'b0;
`endif

endmodule

// File: tb/tb_seq_engine.sv
// Scoreboard bench for seq_engine: expected terms are queued at start and compared on readback.
module tb_seq_engine;

    localparam int WIDTH = 32;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    typedef struct packed {
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [AW:0]      n_terms;
    logic [WIDTH-1:0] seed0, seed1;
    logic [1:0]       op;
    logic             busy, done, ovf;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;

    int n_checks = 0;
    int n_fails  = 0;

    logic [WIDTH-1:0] mdl    [DEPTH];
    bit               mvalid [DEPTH];
    exp_t             sb [$];

    seq_engine #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .n_terms(n_terms),
        .seed0(seed0), .seed1(seed1), .op(op), .busy(busy), .done(done),
        .rd_addr(rd_addr), .rd_data(rd_data), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] apply(input logic [1:0] o, input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
        case (o)
            2'b00:   return x + y;
            2'b01:   return y - x;
            2'b10:   return x ^ y;
            default: return x | y;
        endcase
    endfunction

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rd_addr = e.addr;
            @(negedge clk);
            check($sformatf("mem[%0d]", e.addr), rd_data, e.data);
        end
    endtask

    task automatic check_all();
        exp_t e;
        for (int i = 0; i < DEPTH; i++) begin
            if (mvalid[i]) begin
                e.addr = AW'(i);
                e.data = mdl[i];
                sb.push_back(e);
            end
        end
        drain();
    endtask

    task automatic run(input int nt, input logic [WIDTH-1:0] s0, input logic [WIDTH-1:0] s1,
                       input logic [1:0] o, input bit intrude, input int rw_addr);
        int               nn;
        int               cyc;
        bit               got_done;
        bit               eovf;
        logic [WIDTH-1:0] p2, p1, t, old_rw;
        exp_t             e;

        nn     = (nt > DEPTH) ? DEPTH : nt;
        eovf   = 1'b0;
        old_rw = '0;
        p2     = '0;
        p1     = '0;
        if (rw_addr >= 0) old_rw = mdl[rw_addr];
        for (int i = 0; i < nn; i++) begin
            if (i == 0)      t = s0;
            else if (i == 1) t = s1;
            else begin
                t = apply(o, p2, p1);
                if (o == 2'b00 && ({1'b0, p2} + {1'b0, p1}) > {1'b0, {WIDTH{1'b1}}}) eovf = 1'b1;
                if (o == 2'b01 && p1 < p2) eovf = 1'b1;
            end
            e.addr = AW'(i);
            e.data = t;
            sb.push_back(e);
            mdl[i]    = t;
            mvalid[i] = 1'b1;
            p2 = p1;
            p1 = t;
        end

        start   = 1'b1;
        n_terms = (AW + 1)'(nt);
        seed0   = s0;
        seed1   = s1;
        op      = o;
        @(negedge clk);
        start   = 1'b0;
        n_terms = (AW + 1)'($urandom_range(0, 127));
        seed0   = $urandom;
        seed1   = $urandom;
        op      = 2'($urandom_range(0, 3));
        cyc      = 1;
        got_done = 1'b0;
        while (cyc <= 200) begin
            if (intrude && cyc == 3) begin
                start   = 1'b1;
                seed0   = ~s0;
                seed1   = ~s1;
                n_terms = 7'd3;
            end
            if (intrude && cyc == 4) start = 1'b0;
            if (rw_addr >= 0 && cyc == rw_addr + 1) rd_addr = AW'(rw_addr);
            if (rw_addr >= 0 && cyc == rw_addr + 2) check("rd_during_wr", rd_data, old_rw);
            if (done) begin
                check("done_cycle", cyc, nn + 1);
                check("busy_in_done", busy, 1'b0);
                got_done = 1'b1;
                break;
            end
            check($sformatf("busy_c%0d", cyc), busy, 1'b1);
            @(negedge clk);
            cyc++;
        end
        if (!got_done) check("done_timeout", 1'b0, 1'b1);
`ifdef SEQ_OVF_DETECT_EN
        check("ovf", ovf, eovf);
`else
        check("ovf", ovf, 1'b0);
`endif
        @(negedge clk);
        check("done_single", done, 1'b0);
        check("busy_after", busy, 1'b0);
        drain();
    endtask

    initial begin
        bit saw_done;
        rst     = 1'b1;
        start   = 1'b0;
        n_terms = '0;
        seed0   = '0;
        seed1   = '0;
        op      = '0;
        rd_addr = '0;
        for (int i = 0; i < DEPTH; i++) mvalid[i] = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_rd_data", rd_data, '0);
        rst = 1'b0;
        @(negedge clk);

        run(10, 32'd0, 32'd1, 2'b00, 1'b0, -1);
        run(0, 32'h1234, 32'h5678, 2'b00, 1'b0, -1);
        check_all();
        run(3, 32'd7, 32'd9, 2'b00, 1'b0, -1);
        check_all();
        run(10, 32'd2, 32'd3, 2'b01, 1'b1, -1);
        check_all();
        run(4, 32'hA5, 32'h3C, 2'b10, 1'b0, 2);
        run(6, $urandom, $urandom, 2'b11, 1'b0, -1);
        run(DEPTH + 5, $urandom, $urandom, 2'b00, 1'b0, -1);
        run(5, 32'hFFFF_FFF0, 32'h20, 2'b00, 1'b0, -1);
        run(5, 32'd0, 32'd1, 2'b00, 1'b0, -1);

        start   = 1'b1;
        n_terms = 7'd20;
        seed0   = 32'd1;
        seed1   = 32'd2;
        op      = 2'b00;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_ovf", ovf, 1'b0);
        @(negedge clk);
        check("midrst_rd_data", rd_data, '0);
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) mvalid[i] = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("no_done_after_rst", saw_done, 1'b0);
        run(12, 32'd0, 32'd1, 2'b00, 1'b0, -1);
        run(20, 32'd3, 32'd5, 2'b01, 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
